// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server
// Serves HPS upload (core-to-HPS) reads on the ioctl interface. When the
// upload with index UPLOAD_INDEX starts, the block pauses the core. It then
// fetches each requested byte from a variable-latency memory port and stalls
// HPS with ioctl_wait until that byte is on ioctl_din.
//
// Optional build macro: UPLOAD_CHKSUM_EN
//   When defined, the block keeps an 8-bit running sum of the fetched bytes.
//   A read at addr == DEPTH returns the two's complement of that sum, so the
//   bytes 0..DEPTH of a save file add up to zero. When the macro is not
//   defined, every address >= DEPTH reads as 8'hFF.
module ioctl_upload_server #(
    parameter int          ADDR_W       = 10,
    parameter int          DEPTH        = 1024,
    parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
    parameter int          TIMEOUT      = 64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              err
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    // The full 25-bit address is compared, so high address bits are never
    // silently dropped.
    localparam logic [24:0]     DEPTH_A  = 25'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PAUSE = 3'd1,
        S_READY = 3'd2,
        S_FETCH = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sel_d;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [TMO_W-1:0]   w_tmo_next;

    logic [7:0]         r_din;
    logic               r_wait;
    logic               r_pause_req;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_busy;
    logic               r_err;

    logic [7:0]         w_din_next;
    logic               w_wait_next;
    logic               w_pause_req_next;
    logic               w_mem_req_next;
    logic [ADDR_W-1:0]  w_mem_addr_next;
    logic               w_err_next;

    logic               w_sel;
    logic               w_sel_rise;
    logic               w_in_range;
    logic               w_tmo_hit;
    logic [7:0]         w_oor_data;

`ifdef UPLOAD_CHKSUM_EN
    logic [7:0]         r_sum;
    logic [7:0]         w_sum_next;
`endif

    assign w_sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign w_sel_rise = w_sel && !r_sel_d;
    assign w_in_range = (ioctl_addr < DEPTH_A);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

`ifdef UPLOAD_CHKSUM_EN
    assign w_oor_data = (ioctl_addr == DEPTH_A) ? (~r_sum + 8'd1) : 8'hFF;
`else
    assign w_oor_data = 8'hFF;
`endif

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel_rise) begin
                    w_state_next = S_PAUSE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_PAUSE: begin
                if (!w_sel) begin
                    w_state_next = S_IDLE;
                end else if (pause_ack) begin
                    w_state_next = S_READY;
                end else begin
                    w_state_next = S_PAUSE;
                end
            end
            S_READY: begin
                if (!w_sel) begin
                    w_state_next = S_IDLE;
                end else if (ioctl_rd && w_in_range) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_READY;
                end
            end
            S_FETCH: begin
                if (mem_ack || w_tmo_hit) begin
                    w_state_next = w_sel ? S_READY : S_IDLE;
                end else if (!w_sel) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (mem_ack || w_tmo_hit) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, timeout counter and checksum.
    always_comb begin
        w_din_next       = r_din;
        w_wait_next      = r_wait;
        w_pause_req_next = r_pause_req;
        w_mem_req_next   = r_mem_req;
        w_mem_addr_next  = r_mem_addr;
        w_err_next       = r_err;
        w_tmo_next       = r_tmo_cnt;
`ifdef UPLOAD_CHKSUM_EN
        w_sum_next       = r_sum;
`endif
        case (r_state)
            S_IDLE: begin
                w_mem_req_next = 1'b0;
                if (w_sel_rise) begin
                    w_pause_req_next = 1'b1;
                    w_wait_next      = 1'b1;
                    w_err_next       = 1'b0;
`ifdef UPLOAD_CHKSUM_EN
                    w_sum_next       = 8'd0;
`endif
                end else begin
                    w_pause_req_next = 1'b0;
                    w_wait_next      = 1'b0;
                end
            end
            S_PAUSE: begin
                if (!w_sel) begin
                    w_pause_req_next = 1'b0;
                    w_wait_next      = 1'b0;
                end else if (pause_ack) begin
                    w_wait_next      = 1'b0;
                end else begin
                    w_wait_next      = 1'b1;
                end
            end
            S_READY: begin
                if (!w_sel) begin
                    w_pause_req_next = 1'b0;
                    w_wait_next      = 1'b0;
                end else if (ioctl_rd && w_in_range) begin
                    w_mem_addr_next  = ioctl_addr[ADDR_W-1:0];
                    w_mem_req_next   = 1'b1;
                    w_wait_next      = 1'b1;
                    w_tmo_next       = '0;
                end else if (ioctl_rd) begin
                    w_din_next       = w_oor_data;
                end else begin
                    w_wait_next      = 1'b0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    w_mem_req_next = 1'b0;
                    w_wait_next    = 1'b0;
                    if (w_sel) begin
                        w_din_next = mem_data;
`ifdef UPLOAD_CHKSUM_EN
                        w_sum_next = r_sum + mem_data;
`endif
                    end else begin
                        w_pause_req_next = 1'b0;
                    end
                end else if (w_tmo_hit) begin
                    w_mem_req_next = 1'b0;
                    w_wait_next    = 1'b0;
                    w_err_next     = 1'b1;
                    if (w_sel) begin
                        w_din_next = 8'h00;
                    end else begin
                        w_pause_req_next = 1'b0;
                    end
                end else begin
                    w_tmo_next = r_tmo_cnt + TMO_W'(1);
                    // Once the upload is gone HPS is no longer stalled; the
                    // outstanding fetch is drained silently.
                    w_wait_next = w_sel;
                end
            end
            S_DRAIN: begin
                w_wait_next = 1'b0;
                if (mem_ack || w_tmo_hit) begin
                    w_mem_req_next   = 1'b0;
                    w_pause_req_next = 1'b0;
                    w_err_next       = r_err | (w_tmo_hit & ~mem_ack);
                end else begin
                    w_tmo_next = r_tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                w_mem_req_next   = 1'b0;
                w_pause_req_next = 1'b0;
                w_wait_next      = 1'b0;
            end
        endcase
    end

    // Output, edge-detect, timeout and checksum registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sel_d     <= 1'b0;
            r_tmo_cnt   <= '0;
            r_din       <= 8'h00;
            r_wait      <= 1'b0;
            r_pause_req <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef UPLOAD_CHKSUM_EN
            r_sum       <= 8'd0;
`endif
        end else begin
            r_sel_d     <= w_sel;
            r_tmo_cnt   <= w_tmo_next;
            r_din       <= w_din_next;
            r_wait      <= w_wait_next;
            r_pause_req <= w_pause_req_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_addr  <= w_mem_addr_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_err       <= w_err_next;
`ifdef UPLOAD_CHKSUM_EN
            r_sum       <= w_sum_next;
`endif
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign pause_req  = r_pause_req;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Self-checking bench for ioctl_upload_server (DEPTH=1024, TIMEOUT=64).
// Expected read data is queued when a read is issued and popped when the
// DUT releases ioctl_wait.
module tb_ioctl_upload_server;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        busy;
    logic        err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  sum_m;

    ioctl_upload_server #(
        .ADDR_W(10), .DEPTH(1024), .UPLOAD_INDEX(8'd4), .TIMEOUT(64)
    ) u_dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .busy(busy), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Read that is served from memory after 'lat' cycles.
    task automatic do_fetch(input logic [24:0] addr, input int lat, input logic [7:0] data);
        logic [7:0] exp_v;
        exp_q.push_back(data);
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b1 || ioctl_wait !== 1'b1 || mem_addr !== addr[9:0]) begin
            n_err++;
            $display("FAIL fetch_start addr=%h: mem_req=%b wait=%b mem_addr=%h, required 1 1 %h",
                     addr, mem_req, ioctl_wait, mem_addr, addr[9:0]);
        end
        for (int i = 1; i < lat; i++) begin
            tick();
            n_cmp++;
            if (ioctl_wait !== 1'b1 || mem_req !== 1'b1) begin
                n_err++;
                $display("FAIL fetch_stall cyc=%0d: wait=%b mem_req=%b, required 1 1", i + 1, ioctl_wait, mem_req);
            end
        end
        mem_data = data;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        sum_m    = sum_m + data;
        exp_v    = exp_q.pop_front();
        n_cmp++;
        if (ioctl_wait !== 1'b0 || mem_req !== 1'b0 || ioctl_din !== exp_v) begin
            n_err++;
            $display("FAIL fetch_data addr=%h: wait=%b mem_req=%b din=%h, required 0 0 %h",
                     addr, ioctl_wait, mem_req, ioctl_din, exp_v);
        end
    endtask

    // Read that must be answered without touching memory.
    task automatic do_nofetch(input logic [24:0] addr, input logic [7:0] data);
        logic [7:0] exp_v;
        exp_q.push_back(data);
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        exp_v      = exp_q.pop_front();
        n_cmp++;
        if (mem_req !== 1'b0 || ioctl_wait !== 1'b0 || ioctl_din !== exp_v) begin
            n_err++;
            $display("FAIL nofetch addr=%h: mem_req=%b wait=%b din=%h, required 0 0 %h",
                     addr, mem_req, ioctl_wait, ioctl_din, exp_v);
        end
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL nofetch_idle addr=%h: mem_req=%b busy=%b, required 0 1", addr, mem_req, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
        ioctl_addr = 25'd0; pause_ack = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
        sum_m = 8'd0;
        repeat (3) tick();
        n_cmp++;
        if ({ioctl_din, ioctl_wait, pause_req, mem_req, mem_addr, busy, err} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_state: din=%h wait=%b preq=%b mreq=%b maddr=%h busy=%b err=%b, required all 0",
                     ioctl_din, ioctl_wait, pause_req, mem_req, mem_addr, busy, err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_start();
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd3;
        repeat (2) tick();
        n_cmp++;
        if (busy !== 1'b0 || pause_req !== 1'b0) begin
            n_err++;
            $display("FAIL wrong_index: busy=%b preq=%b, required 0 0", busy, pause_req);
        end
        ioctl_index = 8'd4;
        tick();
        n_cmp++;
        if (pause_req !== 1'b1 || ioctl_wait !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start: preq=%b wait=%b busy=%b, required 1 1 1", pause_req, ioctl_wait, busy);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (ioctl_wait !== 1'b1 || pause_req !== 1'b1) begin
                n_err++;
                $display("FAIL pause_wait cyc=%0d: wait=%b preq=%b, required 1 1", i, ioctl_wait, pause_req);
            end
        end
        pause_ack = 1'b1;
        tick();
        n_cmp++;
        if (ioctl_wait !== 1'b0 || pause_req !== 1'b1) begin
            n_err++;
            $display("FAIL pause_ack: wait=%b preq=%b, required 0 1", ioctl_wait, pause_req);
        end
    endtask

    task automatic test_fetch();
        do_fetch(25'h010, 3, 8'h5A);
        do_fetch(25'h3FF, 1, 8'hC3);
        do_fetch(25'h000, 5, 8'h81);
    endtask

    task automatic test_out_of_range();
`ifndef UPLOAD_CHKSUM_EN
        do_nofetch(25'h400, 8'hFF);
`endif
        do_nofetch(25'h401, 8'hFF);
        do_nofetch(25'h1000010, 8'hFF);
    endtask

    task automatic test_timeout();
        logic [7:0] exp_v;
        exp_q.push_back(8'h00);
        ioctl_addr = 25'h020;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            if (i > 1) tick();
            n_cmp++;
            if (ioctl_wait !== 1'b1 || mem_req !== 1'b1) begin
                n_err++;
                $display("FAIL tmo_stall cyc=%0d: wait=%b mem_req=%b, required 1 1", i, ioctl_wait, mem_req);
            end
        end
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (ioctl_wait !== 1'b0 || mem_req !== 1'b0 || err !== 1'b1 || ioctl_din !== exp_v) begin
            n_err++;
            $display("FAIL timeout: wait=%b mem_req=%b err=%b din=%h, required 0 0 1 %h",
                     ioctl_wait, mem_req, err, ioctl_din, exp_v);
        end
        do_fetch(25'h001, 2, 8'h11);
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
    endtask

    task automatic test_restart();
        ioctl_upload = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || pause_req !== 1'b0 || ioctl_wait !== 1'b0) begin
            n_err++;
            $display("FAIL sel_fall: busy=%b preq=%b wait=%b, required 0 0 0", busy, pause_req, ioctl_wait);
        end
        tick();
        ioctl_upload = 1'b1;
        tick();
        sum_m = 8'd0;
        n_cmp++;
        if (err !== 1'b0 || pause_req !== 1'b1 || ioctl_wait !== 1'b1) begin
            n_err++;
            $display("FAIL restart: err=%b preq=%b wait=%b, required 0 1 1", err, pause_req, ioctl_wait);
        end
        tick();
        n_cmp++;
        if (ioctl_wait !== 1'b0) begin
            n_err++;
            $display("FAIL restart_ready: wait=%b, required 0", ioctl_wait);
        end
    endtask

`ifdef UPLOAD_CHKSUM_EN
    task automatic test_checksum();
        logic [7:0] ck;
        do_fetch(25'h000, 1, 8'h01);
        do_fetch(25'h001, 2, 8'h02);
        do_fetch(25'h002, 1, 8'h03);
        ck = ~sum_m + 8'd1;
        do_nofetch(25'h400, ck);
    endtask
`endif

    task automatic test_drain();
        logic [7:0] din_before;
        din_before = ioctl_din;
        ioctl_addr = 25'h005;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        ioctl_upload = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (mem_req !== 1'b1 || pause_req !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL drain_hold cyc=%0d: mem_req=%b preq=%b busy=%b, required 1 1 1",
                         i, mem_req, pause_req, busy);
            end
        end
        mem_data = 8'h77;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        n_cmp++;
        if (mem_req !== 1'b0 || pause_req !== 1'b0 || busy !== 1'b0 || ioctl_din !== din_before) begin
            n_err++;
            $display("FAIL drain_end: mem_req=%b preq=%b busy=%b din=%h, required 0 0 0 %h",
                     mem_req, pause_req, busy, ioctl_din, din_before);
        end
    endtask

    task automatic test_reset_mid_fetch();
        ioctl_upload = 1'b1;
        repeat (2) tick();
        ioctl_addr = 25'h030;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_fetch_setup: mem_req=%b busy=%b, required 1 1", mem_req, busy);
        end
        reset = 1'b1;
        ioctl_upload = 1'b0;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0 || pause_req !== 1'b0 || ioctl_wait !== 1'b0 || busy !== 1'b0 || ioctl_din !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: mem_req=%b preq=%b wait=%b busy=%b din=%h, required 0 0 0 0 00",
                     mem_req, pause_req, ioctl_wait, busy, ioctl_din);
        end
        mem_data = 8'h99;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        tick();
        n_cmp++;
        if (ioctl_din !== 8'h00 || busy !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL late_ack: din=%h busy=%b mem_req=%b err=%b, required 00 0 0 0",
                     ioctl_din, busy, mem_req, err);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_fetch();
        test_out_of_range();
        test_timeout();
        test_restart();
`ifdef UPLOAD_CHKSUM_EN
        test_checksum();
`endif
        test_drain();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
